// File: rtl/contador_pkg.sv
// Shared types, 7-segment glyphs and the BCD-to-segment decoder.
// Segments are ordered {a,b,c,d,e,f,g} and are active-low.
package contador_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7_decode(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/contador_bcd_mux_bcd_digit.sv
// One BCD decade of the ripple chain; steps only when the lower decades carry/borrow.
// cout is combinational so a whole chain settles within one cycle.
module bcd_digit
  import contador_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic step,
  input  logic up,
  input  logic cin,
  output bcd_t digit,
  output logic cout
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digit <= '0;
    end else if (step && cin) begin
      if (up) begin
        digit <= (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
      end else begin
        // Out-of-range values are folded back to 9 so a decade can never stick above 9.
        digit <= (digit == 4'd0 || digit > 4'd9) ? 4'd9 : digit - 4'd1;
      end
    end
  end

  assign cout = (up ? (digit == 4'd9) : (digit == 4'd0)) & cin;

endmodule

// File: rtl/contador_bcd_mux.sv
// N-decade BCD up/down counter with switch-selected tick prescaler and
// a time-multiplexed, active-low 7-segment display scanner.
module contador_bcd_mux
  import contador_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int CNT_W    = 32,
  parameter int DIV0     = 25000000,
  parameter int DIV1     = 50000000,
  parameter int DIV2     = 100000000,
  parameter int DIV3     = 300000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            sw,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  output logic                  tick,
  output logic                  wrap,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            display,
  output logic [DIGITS-1:0]     an
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  if (DIV0 < 2 || DIV1 < 2 || DIV2 < 2 || DIV3 < 2 || SCAN_DIV < 1 ||
      DIGITS < 1 || DIGITS > 8) begin : g_bad_param
    $error("contador_bcd_mux: need DIVn >= 2, SCAN_DIV >= 1, 1 <= DIGITS <= 8");
  end

  logic [CNT_W-1:0]  presc;
  logic [CNT_W-1:0]  sel;
  logic [1:0]        sw_q;
  logic              step;
  logic [DIGITS:0]   carry;
  bcd_t              digit_q [DIGITS];
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  idx;
  logic [DIGITS-1:0] an_next;

  always_comb begin
    case (sw_q)
      2'd0:    sel = CNT_W'(DIV0);
      2'd1:    sel = CNT_W'(DIV1);
      2'd2:    sel = CNT_W'(DIV2);
      default: sel = CNT_W'(DIV3);
    endcase
  end

  // A rate change restarts the period so the first tick at the new rate is a full one.
  always_ff @(posedge clk) begin
    sw_q <= sw;
    if (rst || clr || (sw != sw_q)) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (en && (presc == sel - CNT_W'(1))) begin
      presc <= '0;
      tick  <= 1'b1;
    end else begin
      if (en) presc <= presc + CNT_W'(1);
      tick <= 1'b0;
    end
  end

  // A pending tick is honoured even if en has just dropped; only clr cancels it.
  assign step     = tick & ~clr;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .step  (step),
      .up    (up),
      .cin   (carry[i]),
      .digit (digit_q[i]),
      .cout  (carry[i+1])
    );
    assign bcd[4*i +: 4] = digit_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) wrap <= 1'b0;
    else            wrap <= step & carry[DIGITS];
  end

  assign an_next = ~(DIGITS'(1) << idx);

  // an and display share one register stage so they always switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= ~DIGITS'(1);
      display  <= SEG_0;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      an      <= an_next;
      display <= seg7_decode(digit_q[idx]);
    end
  end

endmodule

// File: tb/tb_contador_bcd_mux.sv
// Directed bench for contador_bcd_mux with a 2-digit, fast-rate configuration.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_contador_bcd_mux;

  logic       clk = 1'b0;
  logic       rst, en, up, clr;
  logic [1:0] sw;
  logic       tick, wrap;
  logic [7:0] bcd;
  logic [6:0] display;
  logic [1:0] an;

  int n_cmp = 0;
  int n_err = 0;

  contador_bcd_mux #(
    .DIGITS(2), .CNT_W(8), .DIV0(4), .DIV1(8), .DIV2(16), .DIV3(48), .SCAN_DIV(3)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .en(en), .up(up), .clr(clr),
    .tick(tick), .wrap(wrap), .bcd(bcd), .display(display), .an(an)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered one cycle after a count update (presc=1) at DIV0 rate; leaves in the same phase.
  task automatic one_tick(input logic [7:0] exp_bcd, input logic exp_wrap);
    cyc(1);
    chk("wrap_single_cycle", {31'd0, wrap}, 32'd0);
    chk("tick_idle", {31'd0, tick}, 32'd0);
    cyc(2);
    chk("tick_pulse", {31'd0, tick}, 32'd1);
    cyc(1);
    chk("bcd_update", {24'd0, bcd}, {24'd0, exp_bcd});
    chk("wrap_flag", {31'd0, wrap}, {31'd0, exp_wrap});
  endtask

  logic [7:0] down_seq [11] = '{8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04,
                                8'h03, 8'h02, 8'h01, 8'h00, 8'h99};

  initial begin
    int ticks;
    int run;
    logic first;
    logic [1:0] prev_an;

    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; sw = 2'b00;
    cyc(2);
    chk("rst_bcd", {24'd0, bcd}, 32'h00);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_wrap", {31'd0, wrap}, 32'd0);
    chk("rst_an", {30'd0, an}, 32'b10);
    chk("rst_display", {25'd0, display}, 32'b0000001);

    // Up count at DIV0: 0x01..0x09 then the decade carry to 0x10.
    rst = 1'b0; en = 1'b1;
    cyc(1);
    for (int k = 1; k <= 10; k++)
      one_tick((k == 10) ? 8'h10 : 8'(k), 1'b0);

    // Down through the borrow, to 0x00, then wrap to 0x99; up again wraps to 0x00.
    up = 1'b0;
    for (int k = 0; k < 11; k++) one_tick(down_seq[k], (k == 10));
    up = 1'b1;
    one_tick(8'h00, 1'b1);
    one_tick(8'h01, 1'b0);

    // Rate change mid-period restarts the prescaler at DIV3=48.
    cyc(1);
    sw = 2'b11;
    cyc(1);
    ticks = 0;
    for (int i = 0; i < 47; i++) begin cyc(1); if (tick) ticks++; end
    chk("sw_no_early_tick", ticks, 0);
    cyc(1);
    chk("sw_tick_at_48", {31'd0, tick}, 32'd1);
    cyc(1);
    chk("sw_bcd", {24'd0, bcd}, 32'h02);

    // en low for 20 cycles at presc=10 freezes everything; 38 more cycles to the tick.
    cyc(9);
    en = 1'b0;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin cyc(1); if (tick) ticks++; end
    chk("en_freeze_tick", ticks, 0);
    chk("en_freeze_bcd", {24'd0, bcd}, 32'h02);
    en = 1'b1;
    ticks = 0;
    for (int i = 0; i < 37; i++) begin cyc(1); if (tick) ticks++; end
    chk("en_resume_no_tick", ticks, 0);
    cyc(1);
    chk("en_resume_tick", {31'd0, tick}, 32'd1);
    cyc(1);
    chk("en_resume_bcd", {24'd0, bcd}, 32'h03);

    // clr coinciding with tick wins over the pending increment.
    sw = 2'b00;
    cyc(5);
    chk("clr_tick_present", {31'd0, tick}, 32'd1);
    clr = 1'b1;
    cyc(1);
    chk("clr_bcd", {24'd0, bcd}, 32'h00);
    chk("clr_tick", {31'd0, tick}, 32'd0);
    clr = 1'b0;
    cyc(4);
    chk("clr_restart_tick", {31'd0, tick}, 32'd1);
    cyc(1);
    chk("clr_restart_bcd", {24'd0, bcd}, 32'h01);

    // Reset mid-count.
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("rst2_bcd", {24'd0, bcd}, 32'h00);
    chk("rst2_tick", {31'd0, tick}, 32'd0);
    chk("rst2_an", {30'd0, an}, 32'b10);
    chk("rst2_display", {25'd0, display}, 32'b0000001);

    // Count up to 0x37, then hold it and watch the scanner.
    rst = 1'b0;
    cyc(1);
    for (int k = 1; k <= 37; k++)
      one_tick(8'(((k / 10) << 4) | (k % 10)), 1'b0);
    en = 1'b0;
    cyc(2);
    prev_an = an;
    first = 1'b1;
    run = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(1);
      chk("scan_an_onehot", {31'd0, (an == 2'b01) || (an == 2'b10)}, 32'd1);
      if (an == 2'b01) chk("scan_disp_digit1", {25'd0, display}, 32'b0000110);
      else             chk("scan_disp_digit0", {25'd0, display}, 32'b0001111);
      if (an != prev_an) begin
        if (!first) chk("scan_period", run, 3);
        first = 1'b0;
        run = 1;
        prev_an = an;
      end else begin
        run++;
      end
    end
    chk("scan_bcd_held", {24'd0, bcd}, 32'h37);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/contador_bcd_mux.md
Name: contador_bcd_mux

Overview:
- Parametrised N-digit BCD up/down counter with a switch-selectable tick prescaler and a time-multiplexed 7-segment display driver.
- Generalises the single-digit counter/prescaler/decoder chain to DIGITS decades, four parameterised rates, enable/clear/direction control, wrap reporting and anode scanning.
- Sits between board switches/clock and the 7-segment display bank.

Parameters:
- DIGITS, 4: number of BCD decades (1..8).
- CNT_W, 32: prescaler counter width; must hold max(DIV0..DIV3).
- DIV0, 25000000: tick period in clk cycles when sw=00.
- DIV1, 50000000: tick period when sw=01.
- DIV2, 100000000: tick period when sw=10.
- DIV3, 300000000: tick period when sw=11.
- SCAN_DIV, 50000: clk cycles each digit stays lit during scanning.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sw  in  2  rate select (DIV0..DIV3).
- en  in  1  count enable; low freezes the prescaler and the count.
- up  in  1  1 = count up, 0 = count down.
- clr  in  1  synchronous clear of the count and prescaler.
- tick  out  1  one-cycle pulse per prescaler period.
- wrap  out  1  one-cycle pulse when the full count wraps.
- bcd  out  4*DIGITS  packed decades; digit 0 in [3:0].
- display  out  7  segments {a,b,c,d,e,f,g}, active-low.
- an  out  DIGITS  digit enables, active-low, one-hot-low.

Behaviour:
- Reset values, applied on clk edge with rst=1:
  - presc = 0, bcd = 0, tick = 0, wrap = 0.
  - scan counter = 0, scan index = 0.
  - an = all ones except an[0] = 0.
  - display = 7'b0000001 (glyph "0").
- Priority: rst > clr > sw change > normal operation.
- Prescaler:
  - sel = DIV[sw].
  - If en and presc == sel-1: presc <= 0 and tick <= 1 on the next cycle.
  - Else if en: presc increments and tick <= 0.
  - If !en: presc holds and tick <= 0.
  - Period is exactly sel cycles.
- sw change:
  - sw is registered into sw_q.
  - When sw != sw_q: presc <= 0 and tick <= 0 that cycle, so there is no short or long stale period.
- clr: bcd <= 0, presc <= 0, tick <= 0, wrap <= 0. Scanning continues.
- Count update:
  - Applied in the cycle after tick is asserted, i.e. bcd changes on the edge where tick=1 is sampled. Latency from prescaler terminal count to bcd update is 2 cycles.
  - If en drops while tick=1, the pending update is still applied.
- Up count:
  - Digit 0 increments; 9 -> 0 with carry into the next digit.
  - All digits 9 -> all 0, and wrap = 1 for one cycle.
- Down count:
  - Digit 0 decrements; 0 -> 9 with borrow.
  - All digits 0 -> all 9, and wrap = 1.
- The up input is sampled on the update cycle.
- BCD digits never hold values 10..15.
- Scan:
  - Scan counter runs 0..SCAN_DIV-1 independent of en/clr; at terminal count the index advances modulo DIGITS.
  - an and display are registered together one cycle after the index changes, so they are never skewed against each other.
  - display decodes the digit at the current index:
    - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
    - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
    - any other value = 1111111 (blank).
- DIGITS=1: index is constantly 0 and an = 0.
- Elaboration error if any DIVn < 2 or SCAN_DIV < 1.

Decomposition:
- Shared package contador_pkg holds:
  - segment constants SEG_0..SEG_9 and SEG_BLANK;
  - function seg7_decode(4-bit) -> 7-bit;
  - typedef bcd_t (4-bit).
- One sub-module, bcd_digit:
  - Inputs: clk, rst, clr, step, up, cin.
  - Outputs: digit, cout.
  - cout is combinational: (up ? digit==9 : digit==0) & cin.
  - It is generated DIGITS times in a ripple chain.
- Top module contains the prescaler, scan logic and wrap detection.

Test Plan:
Bench parameters: DIGITS=2, DIV0=4, DIV1=8, DIV2=16, DIV3=48, SCAN_DIV=3.
1. rst for 2 cycles, then en=1, up=1, sw=00 -> tick pulses every 4 cycles; bcd reaches 0x09 after 9 ticks and 0x10 on the 10th.
2. Up from 0x99 on tick -> bcd=0x00 and wrap=1 for exactly one cycle; down from 0x00 -> 0x99 with wrap=1; down from 0x10 -> 0x09.
3. sw 00->11 mid-period -> presc restarts; next tick exactly 48 cycles after the change is registered; no tick occurs in between.
4. en=0 for 20 cycles mid-count -> bcd and presc frozen, no tick; after en=1 the remaining cycles of the period elapse before the next tick.
5. clr asserted in the same cycle as tick, and rst asserted mid-count -> bcd=0x00 afterward and no increment applied; after rst, an=2'b10 and display=0000001.
6. bcd=0x37 held -> an alternates 10/01 every 3 cycles; display=0000110 ("3") while an=01 (digit 1 lit) and 0001111 ("7") while an=10 (digit 0 lit), with an and display changing on the same edge.
